// File: rtl/vga_sync_generator_pkg.sv
// Shared 640x480@60 Hz timing constants and the registered-flag bundle.
// The renderer imports this package so both blocks agree on the timing.
package vga_sync_generator_pkg;

  // Horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Sync pulses are active-low on standard VGA monitors
  localparam logic VGA_SYNC_POL = 1'b0;

  // Wide enough for 800 columns and 525 lines
  localparam int VGA_CW = 10;

  // Everything the top level registers apart from the counters themselves
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_start;
    logic line_end;
    logic game_tick;
  } sync_flags_t;

  // Full period of one axis (line length or frame height)
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Flag state while in reset: syncs deasserted, blanked, no pulses
  function automatic sync_flags_t flags_idle(input logic sync_pol);
    sync_flags_t f;
    f             = '0;
    f.hsync       = ~sync_pol;
    f.vsync       = ~sync_pol;
    return f;
  endfunction

endpackage

// File: rtl/vga_sync_generator_sync_axis_counter.sv
// One timing axis: a wrapping counter plus sync/active decode of its next value.
// Used once for columns (step every clock) and once for lines (step on line wrap).
module sync_axis_counter #(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          reset,       // synchronous, active-low
  input  logic          step,
  output logic [CW-1:0] count,       // registered current position
  output logic [CW-1:0] count_next,  // value count takes on this edge
  output logic          wrap,        // this step returns the counter to 0
  output logic          sync_raw,    // next position lies in the sync window
  output logic          active       // next position lies in the visible region
);

  localparam int LAST       = TOTAL - 1;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Using >= means a corrupted out-of-range value wraps to 0 on its next step
  assign wrap = int'(count_q) >= LAST;

  // Next-count: hold, increment, or wrap
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch is inferred.
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
  end

  // Position register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

  // Decode from the next value so the registered flags line up with the registered count
  assign sync_raw = (int'(count_d) >= SYNC_START) && (int'(count_d) < SYNC_END);
  assign active   = int'(count_d) < ACTIVE;

endmodule

// File: rtl/vga_sync_generator.sv
// 640x480@60 Hz VGA timing generator on the 25 MHz pixel clock.
// Produces pixel coordinates, hsync/vsync, video_on and frame/line/game strobes,
// all registered and aligned to the same cycle as the coordinates they describe.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL,
  parameter int   CW       = VGA_CW
) (
  input  logic          vgaCLK,
  input  logic          reset,        // synchronous, active-low
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          frame_start,
  output logic          line_end,
  output logic          game_tick
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Refuse to elaborate with a counter too narrow for the timing
  if (((1 << CW) < H_TOTAL) || ((1 << CW) < V_TOTAL)) begin : g_cw_check
    $error("vga_sync_generator: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_count, h_next;
  logic [CW-1:0] v_count, v_next;
  logic          h_wrap,  v_wrap;
  logic          h_sync_raw, v_sync_raw;
  logic          h_active,   v_active;

  sync_flags_t   flags_d, flags_q;

  sync_axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .CW    (CW)
  ) u_h_axis (
    .clk       (vgaCLK),
    .reset     (reset),
    .step      (1'b1),
    .count     (h_count),
    .count_next(h_next),
    .wrap      (h_wrap),
    .sync_raw  (h_sync_raw),
    .active    (h_active)
  );

  // Lines advance only on the edge where the column counter wraps
  sync_axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .CW    (CW)
  ) u_v_axis (
    .clk       (vgaCLK),
    .reset     (reset),
    .step      (h_wrap),
    .count     (v_count),
    .count_next(v_next),
    .wrap      (v_wrap),
    .sync_raw  (v_sync_raw),
    .active    (v_active)
  );

  // Flags for the position both counters move to on this edge
  always_comb begin
    flags_d             = flags_idle(SYNC_POL);
    flags_d.hsync       = h_sync_raw ? SYNC_POL : ~SYNC_POL;
    flags_d.vsync       = v_sync_raw ? SYNC_POL : ~SYNC_POL;
    flags_d.video_on    = h_active & v_active;
    // Both axes wrapping together is exactly the move to (0,0)
    flags_d.frame_start = h_wrap & v_wrap;
    flags_d.line_end    = int'(h_next) == (H_TOTAL - 1);
    flags_d.game_tick   = (h_next == '0) && (int'(v_next) == V_ACTIVE);
  end

  // Output flag register; reset forces syncs idle and all strobes low
  always_ff @(posedge vgaCLK) begin
    if (!reset) begin
      flags_q <= flags_idle(SYNC_POL);
    end else begin
      flags_q <= flags_d;
    end
  end

  assign hcount      = h_count;
  assign vcount      = v_count;
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign video_on    = flags_q.video_on;
  assign frame_start = flags_q.frame_start;
  assign line_end    = flags_q.line_end;
  assign game_tick   = flags_q.game_tick;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator. Four instances share clock and reset:
// standard 640x480 timing with both sync polarities, and a shrunken 16x12
// timing with both polarities so whole frames fit in a short run.
// A position-index model (pixel number within the frame) predicts every output.
module tb_vga_sync_generator;
  import vga_sync_generator_pkg::*;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic hs, vs, vo, fs, le, gt;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } timing_t;

  typedef struct {
    int   adv;
    obs_t exp;
  } vec_t;

  localparam int SCW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0]     hc0, vc0, hc1, vc1;
  logic [SCW-1:0] hc2, vc2, hc3, vc3;
  logic [3:0]     hs_w, vs_w, vo_w, fs_w, le_w, gt_w;

  vga_sync_generator #(.SYNC_POL(1'b0)) u_std0 (
    .vgaCLK(clk), .reset(reset), .hcount(hc0), .vcount(vc0),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .video_on(vo_w[0]),
    .frame_start(fs_w[0]), .line_end(le_w[0]), .game_tick(gt_w[0]));

  vga_sync_generator #(.SYNC_POL(1'b1)) u_std1 (
    .vgaCLK(clk), .reset(reset), .hcount(hc1), .vcount(vc1),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .video_on(vo_w[1]),
    .frame_start(fs_w[1]), .line_end(le_w[1]), .game_tick(gt_w[1]));

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .CW(SCW)
  ) u_sm0 (
    .vgaCLK(clk), .reset(reset), .hcount(hc2), .vcount(vc2),
    .hsync(hs_w[2]), .vsync(vs_w[2]), .video_on(vo_w[2]),
    .frame_start(fs_w[2]), .line_end(le_w[2]), .game_tick(gt_w[2]));

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .CW(SCW)
  ) u_sm1 (
    .vgaCLK(clk), .reset(reset), .hcount(hc3), .vcount(vc3),
    .hsync(hs_w[3]), .vsync(vs_w[3]), .video_on(vo_w[3]),
    .frame_start(fs_w[3]), .line_end(le_w[3]), .game_tick(gt_w[3]));

  int errors = 0;
  int checks = 0;
  int p[4];
  bit rs[4];

  function automatic timing_t timing_of(input int i);
    timing_t t;
    if (i < 2) t = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:(i == 1)};
    else       t = '{ha:8,   hf:2,  hs:3,  hb:3,  va:6,   vf:1,  vs:2, vb:3,  pol:(i == 3)};
    return t;
  endfunction

  function automatic int frame_len(input timing_t t);
    return (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
  endfunction

  function automatic obs_t mk_obs(input int h, input int v, input bit hs, input bit vs,
                                  input bit vo, input bit fs, input bit le, input bit gt);
    obs_t o;
    o.h = 16'(h); o.v = 16'(v);
    o.hs = hs; o.vs = vs; o.vo = vo; o.fs = fs; o.le = le; o.gt = gt;
    return o;
  endfunction

  // Expected outputs from the pixel index within the frame
  function automatic obs_t model(input timing_t t, input int pp, input bit rst_state);
    int ht, h, v;
    ht = t.ha + t.hf + t.hs + t.hb;
    h  = pp % ht;
    v  = pp / ht;
    if (rst_state) return mk_obs(0, 0, ~t.pol, ~t.pol, 1'b0, 1'b0, 1'b0, 1'b0);
    return mk_obs(h, v,
      (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.pol : ~t.pol,
      (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.pol : ~t.pol,
      (h < t.ha) && (v < t.va), pp == 0, h == ht - 1, (h == 0) && (v == t.va));
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    case (i)
      0:       begin o.h = 16'(hc0); o.v = 16'(vc0); end
      1:       begin o.h = 16'(hc1); o.v = 16'(vc1); end
      2:       begin o.h = 16'(hc2); o.v = 16'(vc2); end
      default: begin o.h = 16'(hc3); o.v = 16'(vc3); end
    endcase
    o.hs = hs_w[i]; o.vs = vs_w[i]; o.vo = vo_w[i];
    o.fs = fs_w[i]; o.le = le_w[i]; o.gt = gt_w[i];
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b le=%b gt=%b, expected h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b le=%b gt=%b",
               name, got.h, got.v, got.hs, got.vs, got.vo, got.fs, got.le, got.gt,
               exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.fs, exp.le, exp.gt);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock with the given reset level; every instance is compared to the model
  task automatic tick(input logic rst_v);
    reset = rst_v;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_v) begin
        p[i]  = 0;
        rs[i] = 1'b1;
      end else begin
        p[i]  = (p[i] + 1) % frame_len(timing_of(i));
        rs[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 4; i++)
      check_obs($sformatf("cycle_inst%0d_p%0d", i, p[i]), observe(i), model(timing_of(i), p[i], rs[i]));
  endtask

  initial begin
    vec_t vecs[12];
    obs_t o, o1;
    int hs_low, hs_first, vo_low, vo_first, le_cnt, le_h, hs_high1;
    int gt_cnt, vs_low, vs_bad, vs_high1, hs_low_s, hs_high_s1;
    int fs_q[$];
    int fs0, fs1, k;

    for (int i = 0; i < 4; i++) begin p[i] = 0; rs[i] = 1'b1; end

    // Column/line landmarks of the standard instance after reset release
    vecs[0]  = '{adv:1,   exp:mk_obs(1,   0, 1, 1, 1, 0, 0, 0)};
    vecs[1]  = '{adv:638, exp:mk_obs(639, 0, 1, 1, 1, 0, 0, 0)};
    vecs[2]  = '{adv:1,   exp:mk_obs(640, 0, 1, 1, 0, 0, 0, 0)};
    vecs[3]  = '{adv:15,  exp:mk_obs(655, 0, 1, 1, 0, 0, 0, 0)};
    vecs[4]  = '{adv:1,   exp:mk_obs(656, 0, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{adv:95,  exp:mk_obs(751, 0, 0, 1, 0, 0, 0, 0)};
    vecs[6]  = '{adv:1,   exp:mk_obs(752, 0, 1, 1, 0, 0, 0, 0)};
    vecs[7]  = '{adv:46,  exp:mk_obs(798, 0, 1, 1, 0, 0, 0, 0)};
    vecs[8]  = '{adv:1,   exp:mk_obs(799, 0, 1, 1, 0, 0, 1, 0)};
    vecs[9]  = '{adv:1,   exp:mk_obs(0,   1, 1, 1, 1, 0, 0, 0)};
    vecs[10] = '{adv:799, exp:mk_obs(799, 1, 1, 1, 0, 0, 1, 0)};
    vecs[11] = '{adv:1,   exp:mk_obs(0,   2, 1, 1, 1, 0, 0, 0)};

    // Reset held for five clocks
    repeat (5) tick(1'b0);
    check_obs("reset_hold_std0", observe(0), mk_obs(0, 0, 1, 1, 0, 0, 0, 0));
    check_obs("reset_hold_std1", observe(1), mk_obs(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      repeat (vecs[i].adv) tick(1'b1);
      check_obs($sformatf("vec%0d", i), observe(0), vecs[i].exp);
    end

    // One whole standard line (line 2): sync width/start, blanking, line_end
    hs_low = 0; hs_first = -1; vo_low = 0; vo_first = -1;
    le_cnt = 0; le_h = -1; hs_high1 = 0;
    for (int n = 0; n < 800; n++) begin
      o  = observe(0);
      o1 = observe(1);
      if (!o.hs) begin hs_low++; if (hs_first < 0) hs_first = int'(o.h); end
      if (!o.vo) begin vo_low++; if (vo_first < 0) vo_first = int'(o.h); end
      if (o.le)  begin le_cnt++; le_h = int'(o.h); end
      if (o1.hs) hs_high1++;
      tick(1'b1);
    end
    check_int("line_hsync_low_clocks", hs_low, 96);
    check_int("line_hsync_first_col", hs_first, 656);
    check_int("line_blank_clocks", vo_low, 160);
    check_int("line_blank_first_col", vo_first, 640);
    check_int("line_end_count", le_cnt, 1);
    check_int("line_end_col", le_h, 799);
    check_int("line_hsync_high_clocks_pol1", hs_high1, 96);
    check_int("line_vcount_after", int'(observe(0).v), 3);

    // Two+ frames of the small timing: frame period, game tick, vsync window
    tick(1'b0);
    gt_cnt = 0; vs_low = 0; vs_bad = 0; vs_high1 = 0; hs_low_s = 0; hs_high_s1 = 0;
    for (int n = 1; n <= 400; n++) begin
      tick(1'b1);
      o  = observe(2);
      o1 = observe(3);
      if (o.fs) fs_q.push_back(n);
      if (o.gt) gt_cnt++;
      if (!o.vs) begin vs_low++; if (o.v < 7 || o.v > 8) vs_bad++; end
      if (!o.hs) hs_low_s++;
      if (o1.vs) vs_high1++;
      if (o1.hs) hs_high_s1++;
    end
    fs0 = (fs_q.size() > 0) ? fs_q[0] : -1;
    fs1 = (fs_q.size() > 1) ? fs_q[1] : -1;
    check_int("frame_start_count", fs_q.size(), 2);
    check_int("frame_start_first", fs0, 192);
    check_int("frame_start_period", fs1 - fs0, 192);
    check_int("game_tick_count", gt_cnt, 2);
    check_int("vsync_low_clocks", vs_low, 64);
    check_int("vsync_outside_window", vs_bad, 0);
    check_int("vsync_high_clocks_pol1", vs_high1, 64);
    check_int("hsync_low_clocks_small", hs_low_s, 75);
    check_int("hsync_high_clocks_small_pol1", hs_high_s1, 75);

    // One-clock reset in mid-frame at (5,4) of the small timing
    tick(1'b0);
    repeat (69) tick(1'b1);
    check_obs("pre_midreset_pos", observe(2), mk_obs(5, 4, 1, 1, 1, 0, 0, 0));
    tick(1'b0);
    check_obs("midreset_sm0", observe(2), mk_obs(0, 0, 1, 1, 0, 0, 0, 0));
    check_obs("midreset_sm1", observe(3), mk_obs(0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin
        tick(1'b1);
        k++;
      end while (!observe(2).fs && k < 500);
      check_int($sformatf("after_midreset_frame%0d_clocks", r), k, 192);
    end

    // Random run with occasional reset pulses; the per-cycle model check covers it
    for (int n = 0; n < 20000; n++) begin
      tick(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
